// File: rtl/odd_gen_arbiter.sv
// Purpose : a 4-way round-robin arbiter. The granted requester receives a burst of
//           odd values 1,3,5,... which wrap modulo 2^(COUNT_LEN+1).
// Latency : a request sampled in IDLE at edge k gives grant and the first beat after edge k.
//           The beat after the final transfer is a DONE cycle, followed by at least one IDLE cycle.
// Backpressure: a beat transfers only when out_valid && out_ready; data and beat count hold otherwise.
//
// Ports:
//   clk, reset         - clock; asynchronous active-high reset
//   req[3:0]           - per-requester burst request
//   req_len            - per-requester burst length, field i at [i*LEN_W +: LEN_W] (0 means 1)
//   grant[3:0]         - one-hot grant while a burst is active
//   out_valid/ready    - beat handshake; out_data is the beat value, out_last marks the final beat
//   busy               - high outside IDLE
//   done/done_id       - one-cycle completion pulse and the index of the finished requester
module odd_gen_arbiter #(
  parameter int COUNT_LEN = 10,
  parameter int LEN_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*LEN_W-1:0] req_len,
  output logic [3:0]         grant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_LEN:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_id
);

  localparam logic [COUNT_LEN:0] DATA_ONE = (COUNT_LEN+1)'(1);
  localparam logic [COUNT_LEN:0] DATA_TWO = (COUNT_LEN+1)'(2);
  localparam logic [LEN_W-1:0]   LEN_ZERO = '0;
  localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       last_id;
  logic [1:0]       cur_id;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;

  // Round-robin search that starts one past the most recently served requester.
  logic             pick_vld;
  logic [1:0]       pick_id;
  logic [1:0]       cand;
  logic [LEN_W-1:0] pick_len;
  logic [LEN_W-1:0] pick_len_eff;
  logic             xfer;
  logic             next_is_last;

  always_comb begin
    pick_vld = 1'b0;
    pick_id  = 2'd0;
    cand     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_id + 2'(k);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  assign pick_len     = req_len[pick_id*LEN_W +: LEN_W];
  assign pick_len_eff = (pick_len == LEN_ZERO) ? LEN_ONE : pick_len;
  assign xfer         = out_valid && out_ready;
  // This is only evaluated on non-final beats, so beat_cnt+1 never exceeds len_q-1.
  assign next_is_last = ((beat_cnt + LEN_ONE) == (len_q - LEN_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_id   <= 2'd3;
      cur_id    <= 2'd0;
      len_q     <= LEN_ONE;
      beat_cnt  <= LEN_ZERO;
      grant     <= 4'b0000;
      out_valid <= 1'b0;
      out_data  <= DATA_ONE;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= BURST;
            cur_id    <= pick_id;
            len_q     <= pick_len_eff;
            beat_cnt  <= LEN_ZERO;
            grant     <= 4'b0001 << pick_id;
            out_valid <= 1'b1;
            out_data  <= DATA_ONE;
            out_last  <= (pick_len_eff == LEN_ONE);
            busy      <= 1'b1;
          end
        end

        BURST: begin
          // req and req_len are deliberately not looked at here: the burst runs to its latched length.
          if (xfer) begin
            if (out_last) begin
              state     <= DONE;
              grant     <= 4'b0000;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= DATA_ONE;
              done      <= 1'b1;
              done_id   <= cur_id;
              last_id   <= cur_id;
            end else begin
              beat_cnt <= beat_cnt + LEN_ONE;
              out_data <= out_data + DATA_TWO;
              out_last <= next_is_last;
            end
          end
        end

        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          done_id <= 2'd0;
        end

        default: begin
          state     <= IDLE;
          grant     <= 4'b0000;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_data  <= DATA_ONE;
          busy      <= 1'b0;
          done      <= 1'b0;
          done_id   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_odd_gen_arbiter.sv
module tb_odd_gen_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic        out_ready;

  logic [3:0]  g1, g2;
  logic        v1, v2, l1, l2, b1, b2, dn1, dn2;
  logic [10:0] d1;
  logic [3:0]  d2;
  logic [1:0]  di1, di2;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Default-width instance.
  odd_gen_arbiter #(.COUNT_LEN(10), .LEN_W(4)) u_wide (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len),
    .grant(g1), .out_valid(v1), .out_ready(out_ready), .out_data(d1),
    .out_last(l1), .busy(b1), .done(dn1), .done_id(di1)
  );

  // Narrow instance, used to show wrap-around of the odd sequence.
  odd_gen_arbiter #(.COUNT_LEN(3), .LEN_W(4)) u_narrow (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len),
    .grant(g2), .out_valid(v2), .out_ready(out_ready), .out_data(d2),
    .out_last(l2), .busy(b2), .done(dn2), .done_id(di2)
  );

  // Reference model: an abstract phase, the served index, a beat number and a burst length.
  // Expected data is computed as (1 + 2*beat) mod 2^W.
  int m_phase;   // 0 idle, 1 burst, 2 done
  int m_id, m_last, m_beat, m_len;

  task automatic model_reset();
    m_phase = 0; m_last = 3; m_id = 0; m_beat = 0; m_len = 1;
  endtask

  task automatic model_step();
    int f;
    if (reset) begin
      model_reset();
    end else begin
      case (m_phase)
        0: begin
          for (int k = 1; k <= 4; k++) begin
            if (m_phase == 0 && req[(m_last + k) % 4]) begin
              m_id    = (m_last + k) % 4;
              f       = int'(req_len >> (4 * m_id)) & 15;
              m_len   = (f == 0) ? 1 : f;
              m_beat  = 0;
              m_phase = 1;
            end
          end
        end
        1: begin
          if (out_ready) begin
            if (m_beat == m_len - 1) begin
              m_phase = 2;
              m_last  = m_id;
            end else begin
              m_beat++;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    int eg, ev, el, eb, ed, edi, e1, e2;
    eg  = (m_phase == 1) ? (1 << m_id) : 0;
    ev  = (m_phase == 1) ? 1 : 0;
    el  = (m_phase == 1 && m_beat == m_len - 1) ? 1 : 0;
    eb  = (m_phase != 0) ? 1 : 0;
    ed  = (m_phase == 2) ? 1 : 0;
    edi = (m_phase == 2) ? m_last : 0;
    e1  = (m_phase == 1) ? ((1 + 2 * m_beat) % 2048) : 1;
    e2  = (m_phase == 1) ? ((1 + 2 * m_beat) % 16) : 1;
    chk("grant", int'(g1), eg);     chk("grant_n", int'(g2), eg);
    chk("out_valid", int'(v1), ev); chk("out_valid_n", int'(v2), ev);
    chk("out_last", int'(l1), el);  chk("out_last_n", int'(l2), el);
    chk("busy", int'(b1), eb);      chk("busy_n", int'(b2), eb);
    chk("done", int'(dn1), ed);     chk("done_n", int'(dn2), ed);
    chk("done_id", int'(di1), edi); chk("done_id_n", int'(di2), edi);
    chk("out_data", int'(d1), e1);  chk("out_data_n", int'(d2), e2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, int'(g1), 0);
    chk({tag, "_valid"}, int'(v1), 0);
    chk({tag, "_last"}, int'(l1), 0);
    chk({tag, "_data"}, int'(d1), 1);
    chk({tag, "_busy"}, int'(b1), 0);
    chk({tag, "_done"}, int'(dn1), 0);
    chk({tag, "_done_id"}, int'(di1), 0);
    chk({tag, "_data_n"}, int'(d2), 1);
  endtask

  // Drive inputs away from the edge, take one rising edge, advance the model, then settle.
  task automatic step(input logic r, input logic [3:0] q, input logic [15:0] ql, input logic rdy);
    reset = r; req = q; req_len = ql; out_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    logic        rdy;
    logic [3:0]  grant;
    logic        valid;
    int          data;
    logic        last;
    logic        done;
    logic [1:0]  done_id;
    logic        busy;
  } vec_t;

  vec_t vt[18];
  int   grants[$];
  int   exp_order[5];
  logic saw_last;

  initial begin
    // Rows 0-4: one 3-beat burst to requester 0.
    vt[0]  = '{4'b0001, 16'h0003, 1'b1, 4'b0001, 1'b1, 1, 1'b0, 1'b0, 2'd0, 1'b1};
    vt[1]  = '{4'b0000, 16'h0003, 1'b1, 4'b0001, 1'b1, 3, 1'b0, 1'b0, 2'd0, 1'b1};
    vt[2]  = '{4'b0000, 16'h0003, 1'b1, 4'b0001, 1'b1, 5, 1'b1, 1'b0, 2'd0, 1'b1};
    vt[3]  = '{4'b0000, 16'h0003, 1'b1, 4'b0000, 1'b0, 1, 1'b0, 1'b1, 2'd0, 1'b1};
    vt[4]  = '{4'b0000, 16'h0003, 1'b1, 4'b0000, 1'b0, 1, 1'b0, 1'b0, 2'd0, 1'b0};
    // Rows 5-8: requester 2 with a length field of 0, which becomes a single beat; a stall precedes it.
    vt[5]  = '{4'b0100, 16'hF0FF, 1'b0, 4'b0100, 1'b1, 1, 1'b1, 1'b0, 2'd0, 1'b1};
    vt[6]  = '{4'b0000, 16'h0000, 1'b0, 4'b0100, 1'b1, 1, 1'b1, 1'b0, 2'd0, 1'b1};
    vt[7]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1, 1'b0, 1'b1, 2'd2, 1'b1};
    vt[8]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1, 1'b0, 1'b0, 2'd0, 1'b0};
    // Rows 9-17: a 4-beat burst with out_ready toggling. req/len changes mid-burst must be ignored.
    vt[9]  = '{4'b0001, 16'h0004, 1'b1, 4'b0001, 1'b1, 1, 1'b0, 1'b0, 2'd0, 1'b1};
    vt[10] = '{4'b1111, 16'hFFFF, 1'b1, 4'b0001, 1'b1, 3, 1'b0, 1'b0, 2'd0, 1'b1};
    vt[11] = '{4'b1111, 16'hFFFF, 1'b0, 4'b0001, 1'b1, 3, 1'b0, 1'b0, 2'd0, 1'b1};
    vt[12] = '{4'b1111, 16'hFFFF, 1'b1, 4'b0001, 1'b1, 5, 1'b0, 1'b0, 2'd0, 1'b1};
    vt[13] = '{4'b1111, 16'hFFFF, 1'b0, 4'b0001, 1'b1, 5, 1'b0, 1'b0, 2'd0, 1'b1};
    vt[14] = '{4'b1111, 16'hFFFF, 1'b1, 4'b0001, 1'b1, 7, 1'b1, 1'b0, 2'd0, 1'b1};
    vt[15] = '{4'b1111, 16'hFFFF, 1'b0, 4'b0001, 1'b1, 7, 1'b1, 1'b0, 2'd0, 1'b1};
    vt[16] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1, 1'b0, 1'b1, 2'd0, 1'b1};
    vt[17] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1, 1'b0, 1'b0, 2'd0, 1'b0};

    // Reset: asynchronous, so outputs settle before any clock edge.
    reset = 1'b1; req = 4'b0000; req_len = 16'h0000; out_ready = 1'b0;
    model_reset();
    #2;
    chk_reset_vals("reset");
    @(negedge clk);

    // Table-driven directed vectors.
    for (int i = 0; i < 18; i++) begin
      step(1'b0, vt[i].req, vt[i].len, vt[i].rdy);
      chk($sformatf("vec%0d_grant", i), int'(g1), int'(vt[i].grant));
      chk($sformatf("vec%0d_valid", i), int'(v1), int'(vt[i].valid));
      chk($sformatf("vec%0d_data", i), int'(d1), vt[i].data);
      chk($sformatf("vec%0d_last", i), int'(l1), int'(vt[i].last));
      chk($sformatf("vec%0d_done", i), int'(dn1), int'(vt[i].done));
      chk($sformatf("vec%0d_done_id", i), int'(di1), int'(vt[i].done_id));
      chk($sformatf("vec%0d_busy", i), int'(b1), int'(vt[i].busy));
    end

    // Round-robin order with every request held and all lengths 1.
    step(1'b1, 4'b0000, 16'h0000, 1'b1);
    exp_order = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 15; c++) begin
      step(1'b0, 4'b1111, 16'h1111, 1'b1);
      chk_model();
      if (v1) begin
        for (int j = 0; j < 4; j++) if (g1[j]) grants.push_back(j);
        chk("rr_spacing_phase", c % 3, 0);
      end
    end
    chk("rr_grant_count", grants.size(), 5);
    for (int j = 0; j < 5 && j < grants.size(); j++)
      chk($sformatf("rr_order%0d", j), grants[j], exp_order[j]);

    // Wrap-around on the narrow instance: a 10-beat burst ends on value 3.
    step(1'b1, 4'b0000, 16'h0000, 1'b1);
    saw_last = 1'b0;
    for (int c = 0; c < 13; c++) begin
      step(1'b0, (c == 0) ? 4'b0001 : 4'b0000, 16'h000A, 1'b1);
      chk_model();
      if (l2 && !saw_last) begin
        saw_last = 1'b1;
        chk("wrap_last_value", int'(d2), 3);
        chk("wrap_last_beatno", c + 1, 10);
      end
    end
    chk("wrap_saw_last", int'(saw_last), 1);

    // Mid-burst reset: abort after the second beat with no done pulse, then restart from 1.
    step(1'b0, 4'b0001, 16'h0005, 1'b1);
    chk_model();
    step(1'b0, 4'b0000, 16'h0005, 1'b1);
    chk_model();
    chk("abort_beat2", int'(d1), 3);
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    @(posedge clk);
    model_reset();
    #1;
    chk_reset_vals("abort_hold");
    step(1'b0, 4'b0001, 16'h0005, 1'b1);
    chk_model();
    chk("restart_data", int'(d1), 1);
    chk("restart_grant", int'(g1), 1);

    // Randomized traffic with occasional resets, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 199) == 0), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           16'($urandom), ($urandom_range(0, 3) != 0));
      chk_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
